branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// ============================================================================
//  Module   : branch_target_buffer
//  Brief    : 2-way set-associative BTB, zero-latency lookup, EX-stage update.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package btb_pkg;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] target;
        logic        hit;
    } BTB_O;
endpackage

module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output BTB_O        btb_o,
    input  logic        ex_valid,
    input  rv32i_opcode ex_opcode,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_br_en,
    input  logic        stall
);

    localparam int WAYS  = 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    logic [WAYS-1:0][SETS-1:0]             valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0][TAG_W-1:0]  tag_q,   tag_d;
    logic [WAYS-1:0][SETS-1:0][31:0]       target_q, target_d;
    logic [SETS-1:0]                       lru_q,   lru_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit0, if_hit1;
    logic             ex_hit0, ex_hit1;
    logic             update_en;
    logic             wr_way;
    logic             unused_bits;

    assign if_idx = if_pc[2 +: IDX_W];
    assign if_tag = if_pc[31 -: TAG_W];
    assign ex_idx = ex_pc[2 +: IDX_W];
    assign ex_tag = ex_pc[31 -: TAG_W];
    assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads registered state only, so same-cycle updates are not bypassed.
    always_comb begin
        if_hit0 = valid_q[0][if_idx] && (tag_q[0][if_idx] == if_tag);
        if_hit1 = valid_q[1][if_idx] && (tag_q[1][if_idx] == if_tag);
        btb_o.hit = if_hit0 | if_hit1;
        if (if_hit0) begin
            btb_o.target = target_q[0][if_idx];
        end else if (if_hit1) begin
            btb_o.target = target_q[1][if_idx];
        end else begin
            btb_o.target = 32'h0;
        end
    end

    always_comb begin
        update_en = ex_valid & ~stall & ~rst &
                    ((ex_opcode == op_jal) | (ex_opcode == op_jalr) |
                     ((ex_opcode == op_br) & ex_br_en));
        ex_hit0 = valid_q[0][ex_idx] && (tag_q[0][ex_idx] == ex_tag);
        ex_hit1 = valid_q[1][ex_idx] && (tag_q[1][ex_idx] == ex_tag);

        // Victim order: matching way, then empty way 0, empty way 1, else LRU.
        if (ex_hit0) begin
            wr_way = 1'b0;
        end else if (ex_hit1) begin
            wr_way = 1'b1;
        end else if (!valid_q[0][ex_idx]) begin
            wr_way = 1'b0;
        end else if (!valid_q[1][ex_idx]) begin
            wr_way = 1'b1;
        end else begin
            wr_way = lru_q[ex_idx];
        end

        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        lru_d    = lru_q;
        if (update_en) begin
            valid_d[wr_way][ex_idx]  = 1'b1;
            tag_d[wr_way][ex_idx]    = ex_tag;
            target_d[wr_way][ex_idx] = ex_target;
            lru_d[ex_idx]            = ~wr_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

`default_nettype wire
